// File: rtl/round_pipe.sv
// Rounds a wide mantissa (hidden+fraction+guard/sticky) to MAN_W bits, with four rounding modes.
// Latency: 2 cycles from input acceptance to out_valid.
// Backpressure: whole-pipe stall; both stages hold while out_valid & ~out_ready, and in_ready follows.
module round_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int GUARD_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sign,
  input  logic [EXP_W-1:0]               in_exp,
  input  logic [MAN_W+GUARD_W:0]         in_man,
  input  logic [1:0]                     in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sign,
  output logic [EXP_W-1:0]               out_exp,
  output logic [MAN_W-1:0]               out_man,
  output logic                           out_inexact,
  output logic                           out_overflow
);

  localparam int MI = MAN_W + GUARD_W + 1;

  localparam logic [1:0] MODE_RNE = 2'b00;
  localparam logic [1:0] MODE_RTZ = 2'b01;
  localparam logic [1:0] MODE_RUP = 2'b10;
  localparam logic [1:0] MODE_RDN = 2'b11;

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // Round bits pulled out of the incoming mantissa.
  logic lsb_bit, guard_bit, sticky_bit, special;
  assign lsb_bit    = in_man[GUARD_W];
  assign guard_bit  = in_man[GUARD_W-1];
  assign sticky_bit = |in_man[GUARD_W-2:0];
  assign special    = &in_exp;

  logic             inc_c;
  logic [MAN_W+1:0] sum_c;

  // Increment decision per rounding mode; inf/NaN operands are never rounded.
  always_comb begin
    inc_c = 1'b0;
    case (in_mode)
      MODE_RNE: inc_c = guard_bit & (sticky_bit | lsb_bit);
      MODE_RTZ: inc_c = 1'b0;
      MODE_RUP: inc_c = ~in_sign & (guard_bit | sticky_bit);
      MODE_RDN: inc_c = in_sign & (guard_bit | sticky_bit);
      default:  inc_c = 1'b0;
    endcase
    if (special) inc_c = 1'b0;
    sum_c = {1'b0, in_man[MI-1:GUARD_W]} + {{(MAN_W+1){1'b0}}, inc_c};
  end

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_hid;
  logic             s1_inexact;
  logic [MAN_W+1:0] s1_sum;

  // Stage 1: capture operand, incremented mantissa and inexact flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_hid     <= 1'b0;
      s1_inexact <= 1'b0;
      s1_sum     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_sign;
        s1_exp     <= in_exp;
        s1_hid     <= in_man[MI-1];
        s1_inexact <= (guard_bit | sticky_bit) & ~special;
        s1_sum     <= sum_c;
      end
    end
  end

  logic [EXP_W:0]   exp_n;
  logic [MAN_W-1:0] man_n;
  logic             ovf_n;

  // Stage 2 combinational: renormalise on carry, promote subnormals, saturate to inf.
  always_comb begin
    exp_n = {1'b0, s1_exp};
    man_n = s1_sum[MAN_W-1:0];
    ovf_n = 1'b0;
    if (s1_sum[MAN_W+1]) begin
      exp_n = {1'b0, s1_exp} + {{EXP_W{1'b0}}, 1'b1};
      man_n = '0;
    end else if (s1_exp == '0 && !s1_hid && s1_sum[MAN_W]) begin
      exp_n = {{EXP_W{1'b0}}, 1'b1};
    end
    if (s1_sum[MAN_W+1] && exp_n >= EXP_MAX) begin
      exp_n = EXP_MAX;
      man_n = '0;
      ovf_n = 1'b1;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exp      <= '0;
      out_man      <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign     <= s1_sign;
        out_exp      <= exp_n[EXP_W-1:0];
        out_man      <= man_n;
        out_inexact  <= s1_inexact;
        out_overflow <= ovf_n;
      end
    end
  end

endmodule

// File: tb/tb_round_pipe.sv
module tb_round_pipe;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int GW = 4;
  localparam int MI = MW + GW + 1;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-1:0] man;
    logic          inexact;
    logic          ovf;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MI-1:0] in_man;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_man;
  logic          out_inexact;
  logic          out_overflow;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t q[$];
  res_t pend;

  round_pipe #(.EXP_W(EW), .MAN_W(MW), .GUARD_W(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_man(out_man),
    .out_inexact(out_inexact), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: round the real-valued mantissa by comparing the discarded remainder to one half.
  function automatic res_t model(input logic s, input logic [EW-1:0] e,
                                 input logic [MI-1:0] m, input logic [1:0] md);
    res_t        r;
    longint      top, rem, half, v, ex;
    bit          up;
    top  = longint'(m) >> GW;
    rem  = longint'(m) % (64'sd1 << GW);
    half = 64'sd1 << (GW - 1);
    r.sign = s;
    if (e == 8'hFF) begin
      r.exp = e; r.man = top[MW-1:0]; r.inexact = 1'b0; r.ovf = 1'b0;
      return r;
    end
    case (md)
      2'd0:    up = (rem > half) || (rem == half && top[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = (rem != 0) && !s;
      default: up = (rem != 0) && s;
    endcase
    v  = top + (up ? 1 : 0);
    ex = longint'(e);
    if (v >= (64'sd1 << (MW + 1))) begin
      ex = ex + 1;
      v  = 0;
    end else if (e == 0 && top < (64'sd1 << MW) && v >= (64'sd1 << MW)) begin
      ex = 1;
    end
    r.ovf = (ex >= 255);
    if (r.ovf) begin ex = 255; v = 0; end
    r.exp     = ex[EW-1:0];
    r.man     = v[MW-1:0];
    r.inexact = (rem != 0);
    return r;
  endfunction

  // One clock: check any presented result against the scoreboard head, record input transfer.
  task automatic tick(output bit acc);
    #1;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        chk("out_sign", 64'(out_sign), 64'(q[0].sign));
        chk("out_exp", 64'(out_exp), 64'(q[0].exp));
        chk("out_man", 64'(out_man), 64'(q[0].man));
        chk("out_inexact", 64'(out_inexact), 64'(q[0].inexact));
        chk("out_overflow", 64'(out_overflow), 64'(q[0].ovf));
        if (out_ready) void'(q.pop_front());
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(pend);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic [EW-1:0] e,
                        input logic [MI-1:0] m, input logic [1:0] md);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m; in_mode = md;
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (q.size() > 0 || out_valid === 1'b1); i++) tick(a);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Directed single op whose expected result is a hand-derived constant.
  task automatic send_const(input logic s, input logic [EW-1:0] e, input logic [MI-1:0] m,
                            input logic [1:0] md, input res_t want);
    bit a;
    set_in(s, e, m, md);
    pend = want;
    tick(a);
    chk("const_accepted", 64'(a), 64'd1);
    in_valid = 1'b0;
  endtask

  function automatic res_t mk(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                              input logic ix, input logic ov);
    res_t r;
    r.sign = s; r.exp = e; r.man = m; r.inexact = ix; r.ovf = ov;
    return r;
  endfunction

  logic [MI-1:0] rmask;
  logic [MI-1:0] rman;
  logic [EW-1:0] rexp;
  logic          rsign;
  logic [1:0]    rmode;

  task automatic rand_op();
    int pat;
    rmask = {MI{1'b1}};
    rman  = MI'({$urandom, $urandom}) & rmask;
    pat   = $urandom_range(0, 3);
    if (pat == 0) rman[MI-1] = 1'b1;
    if (pat == 1) rman = rman | {{(MW+1){1'b1}}, {GW{1'b0}}};
    if (pat == 2) rman[MI-1] = 1'b0;
    case ($urandom_range(0, 5))
      0:       rexp = 8'h00;
      1:       rexp = 8'hFE;
      2:       rexp = 8'hFF;
      default: rexp = EW'($urandom);
    endcase
    rsign = 1'($urandom);
    rmode = 2'($urandom);
  endtask

  initial begin
    bit a;
    int k;
    int sent;
    bit have;

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
    in_mode = 2'b00; out_ready = 1'b1; pend = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_exp", 64'(out_exp), 64'd0);
    chk("rst_out_man", 64'(out_man), 64'd0);
    chk("rst_flags", 64'({out_sign, out_inexact, out_overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: first op after reset appears exactly two cycles later.
    send_const(1'b0, 8'h80, 28'h8000008, 2'b00, mk(1'b0, 8'h80, 23'h000000, 1'b1, 1'b0));
    #1 chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    tick(a);
    #1 chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    drain();

    send_const(1'b0, 8'h80, 28'h8000018, 2'b00, mk(1'b0, 8'h80, 23'h000002, 1'b1, 1'b0));
    send_const(1'b0, 8'h80, 28'hFFFFFF8, 2'b00, mk(1'b0, 8'h81, 23'h000000, 1'b1, 1'b0));
    send_const(1'b0, 8'hFE, 28'hFFFFFFF, 2'b00, mk(1'b0, 8'hFF, 23'h000000, 1'b1, 1'b1));
    send_const(1'b0, 8'hFE, 28'hFFFFFFF, 2'b01, mk(1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0));
    send_const(1'b1, 8'hFE, 28'hFFFFFFF, 2'b10, mk(1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 1'b0));
    send_const(1'b1, 8'hFE, 28'hFFFFFFF, 2'b11, mk(1'b1, 8'hFF, 23'h000000, 1'b1, 1'b1));
    send_const(1'b0, 8'h00, 28'h7FFFFF8, 2'b00, mk(1'b0, 8'h01, 23'h000000, 1'b1, 1'b0));
    send_const(1'b0, 8'hFF, 28'h1234567, 2'b10, mk(1'b0, 8'hFF, 23'h123456, 1'b0, 1'b0));
    send_const(1'b0, 8'h40, 28'h8000001, 2'b10, mk(1'b0, 8'h40, 23'h000001, 1'b1, 1'b0));
    drain();

    // Three back-to-back operands with the consumer stalled for three cycles.
    k = 0;
    for (int cyc = 0; cyc < 30 && (k < 3 || q.size() > 0); cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 5);
      if (k < 3) begin
        set_in(1'b0, 8'h10 + EW'(k), 28'h8000018 + MI'(k << GW), 2'b00);
        pend = model(in_sign, in_exp, in_man, in_mode);
      end else begin
        in_valid = 1'b0;
      end
      if (cyc >= 2 && cyc < 5) begin
        #1;
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      tick(a);
      if (a) k++;
    end
    chk("b2b_all_sent", 64'(k), 64'd3);
    drain();

    // Randomized traffic with random backpressure, checked against the reference model.
    have = 1'b0;
    sent = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        rand_op();
        set_in(rsign, rexp, rman, rmode);
        pend = model(rsign, rexp, rman, rmode);
        have = 1'b1;
      end else if (!have) begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick(a);
      if (a) begin have = 1'b0; sent++; end
    end
    chk("rand_traffic_flowed", 64'(sent > 300), 64'd1);
    drain();

    // Asynchronous reset with both stages full discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 8'h55, 28'h8ABCDEF, 2'b00);
      pend = model(in_sign, in_exp, in_man, in_mode);
      tick(a);
    end
    in_valid = 1'b0;
    #1 chk("full_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_exp", 64'(out_exp), 64'd0);
    chk("arst_out_man", 64'(out_man), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(a);
      #1 chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end

    send_const(1'b1, 8'h7F, 28'h8000009, 2'b11, mk(1'b1, 8'h7F, 23'h000001, 1'b1, 1'b0));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/round_pipe.md
ROUND_PIPE -- requirements
Module: round_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter MAN_W, default 23, stored fraction width.
REQ-003 Parameter GUARD_W, default 4, round-bit width (>=2); MI = MAN_W+GUARD_W+1 is the input mantissa width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  input operand valid.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_sign  in  1  operand sign.
REQ-009 in_exp  in  EXP_W  biased exponent.
REQ-010 in_man  in  MI  [MI-1] hidden bit, [MI-2:GUARD_W] fraction, [GUARD_W-1] guard, [GUARD_W-2:0] sticky field.
REQ-011 in_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out_sign / out_exp / out_man  out  1 / EXP_W / MAN_W  rounded result.
REQ-015 out_inexact  out  1  any round bit was nonzero.
REQ-016 out_overflow  out  1  rounding carried exponent to all-ones or saturated.

Function
REQ-017 Two-stage pipeline; result appears on out_valid exactly 2 enabled cycles after acceptance.
REQ-018 Pipeline enable en = ~out_valid | out_ready; in_ready = en; both stages advance only when en=1 (whole-pipe stall, bubbles not collapsed).
REQ-019 Transfer at input when in_valid & in_ready; at output when out_valid & out_ready; in_mode and in_sign are captured with the data.
REQ-020 Let l = in_man[GUARD_W], g = in_man[GUARD_W-1], s = OR of in_man[GUARD_W-2:0].
REQ-021 Increment decision: RNE g&(s|l); RTZ 0; RUP ~sign&(g|s); RDN sign&(g|s).
REQ-022 Stage 1 registers sign, exp, mode, inc, inexact = g|s, and sum = in_man[MI-1:GUARD_W] + inc at MAN_W+2 bits.
REQ-023 Stage 2: carry-out of sum (bit MAN_W+1) -> exp+1, out_man = 0; else out_man = sum[MAN_W-1:0], exp unchanged.
REQ-024 Subnormal: in_exp=0 with hidden bit 0 and sum[MAN_W]=1 after increment -> out_exp = 1.
REQ-025 Overflow: adjusted exp = all-ones -> RNE: inf (exp all-ones, man 0); RTZ never increments; RUP negative / RDN positive never increment; otherwise inf; out_overflow=1 whenever inf is produced by rounding.
REQ-026 in_exp all-ones (inf/NaN): no increment; out_man = in_man[MI-2:GUARD_W]; out_inexact=0, out_overflow=0.
REQ-027 Exponent arithmetic is EXP_W+1 bits internally; no wrap-around permitted on out_exp.
REQ-028 Outputs are held stable while out_valid & ~out_ready.

Reset
REQ-029 rst_n low asynchronously clears both stage-valid registers; out_valid=0 immediately; in_ready=1 while out_valid=0.
REQ-030 Reset values: out_sign 0, out_exp 0, out_man 0, out_inexact 0, out_overflow 0; in-flight operands are discarded.
REQ-031 After rst_n deasserts, first accepted operand emerges 2 cycles later with out_ready held high.

Verification (EXP_W 8, MAN_W 23, GUARD_W 4)
REQ-032 exp 0x80, man 0x8000008, RNE -> exp 0x80, man 0x000000, inexact 1 (tie to even, no increment).
REQ-033 exp 0x80, man 0x8000018, RNE -> exp 0x80, man 0x000002, inexact 1.
REQ-034 exp 0x80, man 0xFFFFFF8, RNE -> exp 0x81, man 0x000000, inexact 1, overflow 0.
REQ-035 exp 0xFE, man 0xFFFFFFF, sign 0: RNE -> exp 0xFF, man 0, overflow 1; RTZ -> exp 0xFE, man 0x7FFFFF, overflow 0, inexact 1.
REQ-036 Three back-to-back operands, out_ready low 3 cycles -> in_ready low while out_valid & ~out_ready, all 3 results delivered in order, none lost or duplicated.
REQ-037 rst_n pulsed low with both stages full -> out_valid 0 in same cycle, no stale result after release.
